// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package mips_cpu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } multdiv_op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_FIN  = 3'd4
    } multdiv_state_t;

    localparam logic RESET_HI_LO = '0;

endpackage

// File: rtl/mips_cpu_multdiv_divider.sv
// Iterative restoring unsigned divider: one quotient bit per step, WIDTH steps.
module mips_cpu_multdiv_divider
    import mips_cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_last_step
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_divisor;
    logic [CW-1:0]    r_count;
    logic [WIDTH:0]   w_partial;
    logic [WIDTH:0]   w_trial;

    // Shift the next dividend bit into the partial remainder and try a subtract.
    always_comb begin
        w_partial = {r_rem, r_quo[WIDTH-1]};
        w_trial   = w_partial - {1'b0, r_divisor};
    end

    // Load operands on start; otherwise retire one quotient bit per step.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_count   <= '0;
        end else if (i_start) begin
            r_rem     <= '0;
            r_quo     <= i_dividend;
            r_divisor <= i_divisor;
            r_count   <= '0;
        end else if (i_step) begin
            if (!w_trial[WIDTH]) begin
                r_rem <= w_trial[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], 1'b1};
            end else begin
                r_rem <= w_partial[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], 1'b0};
            end
            r_count <= r_count + CW'(1);
        end
    end

    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;
    assign o_last_step = (r_count == CW'(WIDTH - 1));

endmodule

// File: rtl/mips_cpu_multdiv.sv
// HI/LO multiply/divide unit: MULT(U), DIV(U), MTHI, MTLO with valid/ready handshake.
module mips_cpu_multdiv
    import mips_cpu_pkg::*;
#(
    parameter int unsigned WIDTH         = 32,
    parameter bit          MUL_ITERATIVE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             op_valid,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             op_ready,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH);

    multdiv_state_t     r_state;
    multdiv_state_t     w_next_state;

    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_dbz;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_prod;
    logic [CW-1:0]      r_mul_cnt;

    logic               w_accept;
    logic               w_op_signed;
    logic               w_op_div;
    logic               w_op_mul;
    logic               w_b_zero;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_mul_last;
    logic [2*WIDTH-1:0] w_mag_prod;
    logic [2*WIDTH-1:0] w_prod_src;
    logic [2*WIDTH-1:0] w_prod_fixed;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_quo_fixed;
    logic [WIDTH-1:0]   w_rem_fixed;
    logic               w_div_last;
    logic               w_div_start;
    logic               w_div_step;

    // Request decode and operand magnitudes taken from the live ports at acceptance.
    always_comb begin
        w_accept    = clk_enable & op_valid & (r_state == ST_IDLE);
        w_op_signed = (op_code == OP_MULT) || (op_code == OP_DIV);
        w_op_div    = (op_code == OP_DIV)  || (op_code == OP_DIVU);
        w_op_mul    = (op_code == OP_MULT) || (op_code == OP_MULTU);
        w_b_zero    = (op_b == '0);
        w_mag_a     = (w_op_signed && op_a[WIDTH-1]) ? ('0 - op_a) : op_a;
        w_mag_b     = (w_op_signed && op_b[WIDTH-1]) ? ('0 - op_b) : op_b;
        w_div_start = w_accept & w_op_div & ~w_b_zero;
        w_div_step  = clk_enable & (r_state == ST_DIV);
    end

    // Product/quotient sign fix-up; the single-cycle product reuses the same fix-up.
    always_comb begin
        w_mul_last   = (r_mul_cnt == CW'(WIDTH - 1));
        w_mag_prod   = r_mcand * {{WIDTH{1'b0}}, r_mplier};
        w_prod_src   = MUL_ITERATIVE ? r_prod : w_mag_prod;
        w_prod_fixed = r_neg_q ? ('0 - w_prod_src) : w_prod_src;
        w_quo_fixed  = r_neg_q ? ('0 - w_quo) : w_quo;
        w_rem_fixed  = r_neg_r ? ('0 - w_rem) : w_rem;
    end

    mips_cpu_multdiv_divider #(
        .WIDTH(WIDTH)
    ) u_divider (
        .clk         (clk),
        .reset       (reset),
        .i_start     (w_div_start),
        .i_step      (w_div_step),
        .i_dividend  (w_mag_a),
        .i_divisor   (w_mag_b),
        .o_quotient  (w_quo),
        .o_remainder (w_rem),
        .o_last_step (w_div_last)
    );

    // FSM state register; reset wins over clk_enable.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else if (clk_enable) begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (op_valid) begin
                    if (w_op_mul) begin
                        w_next_state = ST_MUL;
                    end else if (w_op_div && !w_b_zero) begin
                        w_next_state = ST_DIV;
                    end else begin
                        w_next_state = ST_FIN;
                    end
                end
            end
            ST_MUL: begin
                if (!MUL_ITERATIVE) begin
                    w_next_state = ST_FIN;
                end else if (w_mul_last) begin
                    w_next_state = ST_FIX;
                end
            end
            ST_DIV: begin
                if (w_div_last) begin
                    w_next_state = ST_FIX;
                end
            end
            ST_FIX:  w_next_state = ST_FIN;
            ST_FIN:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Datapath: operand capture, shift-add steps, HI/LO writes, done and sticky flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hi      <= {WIDTH{RESET_HI_LO}};
            r_lo      <= {WIDTH{RESET_HI_LO}};
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
            r_is_div  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_prod    <= '0;
            r_mul_cnt <= '0;
        end else if (clk_enable) begin
            r_done <= (w_next_state == ST_FIN);
            if (w_accept) begin
                r_dbz     <= w_op_div & w_b_zero;
                r_is_div  <= w_op_div;
                r_neg_q   <= w_op_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                r_neg_r   <= w_op_signed & op_a[WIDTH-1];
                r_mcand   <= {{WIDTH{1'b0}}, w_mag_a};
                r_mplier  <= w_mag_b;
                r_prod    <= '0;
                r_mul_cnt <= '0;
                if (op_code == OP_MTHI) begin
                    r_hi <= op_a;
                end
                if (op_code == OP_MTLO) begin
                    r_lo <= op_a;
                end
            end
            case (r_state)
                ST_MUL: begin
                    if (!MUL_ITERATIVE) begin
                        {r_hi, r_lo} <= w_prod_fixed;
                    end else begin
                        if (r_mplier[0]) begin
                            r_prod <= r_prod + r_mcand;
                        end
                        r_mcand   <= r_mcand << 1;
                        r_mplier  <= r_mplier >> 1;
                        r_mul_cnt <= r_mul_cnt + CW'(1);
                    end
                end
                ST_FIX: begin
                    if (r_is_div) begin
                        r_lo <= w_quo_fixed;
                        r_hi <= w_rem_fixed;
                    end else begin
                        {r_hi, r_lo} <= w_prod_fixed;
                    end
                end
                default: ;
            endcase
        end
    end

    assign op_ready    = (r_state == ST_IDLE);
    assign busy        = ~op_ready;
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule

// File: tb/tb_mips_cpu_multdiv.sv
// Directed bench for mips_cpu_multdiv: single-cycle and iterative multiplier instances.
module tb_mips_cpu_multdiv;
    import mips_cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable;
    logic        valid0;
    logic        valid1;
    logic [2:0]  op_code;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        ready0, busy0, done0, dbz0;
    logic        ready1, busy1, done1, dbz1;
    logic [31:0] hi0, lo0, hi1, lo1;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    mips_cpu_multdiv #(.WIDTH(32), .MUL_ITERATIVE(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .op_valid(valid0),
        .op_code(op_code), .op_a(op_a), .op_b(op_b), .op_ready(ready0), .busy(busy0),
        .done(done0), .div_by_zero(dbz0), .hi(hi0), .lo(lo0)
    );

    mips_cpu_multdiv #(.WIDTH(32), .MUL_ITERATIVE(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .op_valid(valid1),
        .op_code(op_code), .op_a(op_a), .op_b(op_b), .op_ready(ready1), .busy(busy1),
        .done(done1), .div_by_zero(dbz1), .hi(hi1), .lo(lo1)
    );

    // Issue one op on the selected instance and return the latency (accept cycle = 1).
    task automatic run_op(input bit it, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int lat);
        int guard = 0;
        while (!(it ? ready1 : ready0) && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        op_code = op; op_a = a; op_b = b;
        if (it) valid1 = 1'b1; else valid0 = 1'b1;
        @(posedge clk); #1;
        valid0 = 1'b0; valid1 = 1'b0;
        op_a = 32'hDEADBEEF; op_b = 32'h0BADF00D;
        lat = 1;
        while (!(it ? done1 : done0) && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; clk_enable = 1'b1; valid0 = 1'b0; valid1 = 1'b0;
        op_code = 3'd0; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (hi0 !== 32'h0) begin n_miss++; $display("FAIL reset_hi: got %h want %h", hi0, 32'h0); end
        n_vec++; if (lo0 !== 32'h0) begin n_miss++; $display("FAIL reset_lo: got %h want %h", lo0, 32'h0); end
        n_vec++; if (ready0 !== 1'b1 || busy0 !== 1'b0) begin n_miss++; $display("FAIL reset_ready: got %b/%b want 1/0", ready0, busy0); end
        n_vec++; if (done0 !== 1'b0 || dbz0 !== 1'b0) begin n_miss++; $display("FAIL reset_flags: got %b/%b want 0/0", done0, dbz0); end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mult();
        int lat;
        run_op(1'b0, OP_MULT, 32'hFFFFFFFE, 32'd3, lat);
        n_vec++; if (lat != 2) begin n_miss++; $display("FAIL mult_lat: got %0d want 2", lat); end
        n_vec++; if (hi0 !== 32'hFFFFFFFF) begin n_miss++; $display("FAIL mult_hi: got %h want %h", hi0, 32'hFFFFFFFF); end
        n_vec++; if (lo0 !== 32'hFFFFFFFA) begin n_miss++; $display("FAIL mult_lo: got %h want %h", lo0, 32'hFFFFFFFA); end
        n_vec++; if (busy0 !== 1'b1 || ready0 !== 1'b0) begin n_miss++; $display("FAIL fin_busy: got %b/%b want 1/0", busy0, ready0); end
        run_op(1'b0, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
        n_vec++; if (lat != 2) begin n_miss++; $display("FAIL multu_lat: got %0d want 2", lat); end
        n_vec++; if (hi0 !== 32'hFFFFFFFE) begin n_miss++; $display("FAIL multu_hi: got %h want %h", hi0, 32'hFFFFFFFE); end
        n_vec++; if (lo0 !== 32'h00000001) begin n_miss++; $display("FAIL multu_lo: got %h want %h", lo0, 32'h1); end
    endtask

    task automatic test_mult_iterative();
        int lat;
        run_op(1'b1, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
        n_vec++; if (lat != 34) begin n_miss++; $display("FAIL imultu_lat: got %0d want 34", lat); end
        n_vec++; if (hi1 !== 32'hFFFFFFFE) begin n_miss++; $display("FAIL imultu_hi: got %h want %h", hi1, 32'hFFFFFFFE); end
        n_vec++; if (lo1 !== 32'h00000001) begin n_miss++; $display("FAIL imultu_lo: got %h want %h", lo1, 32'h1); end
        run_op(1'b1, OP_MULT, 32'hFFFFFFFE, 32'd3, lat);
        n_vec++; if (lat != 34) begin n_miss++; $display("FAIL imult_lat: got %0d want 34", lat); end
        n_vec++; if (hi1 !== 32'hFFFFFFFF) begin n_miss++; $display("FAIL imult_hi: got %h want %h", hi1, 32'hFFFFFFFF); end
        n_vec++; if (lo1 !== 32'hFFFFFFFA) begin n_miss++; $display("FAIL imult_lo: got %h want %h", lo1, 32'hFFFFFFFA); end
    endtask

    task automatic test_div();
        int lat;
        run_op(1'b0, OP_DIV, 32'hFFFFFFF9, 32'd2, lat);
        n_vec++; if (lat != 34) begin n_miss++; $display("FAIL div_lat: got %0d want 34", lat); end
        n_vec++; if (lo0 !== 32'hFFFFFFFD) begin n_miss++; $display("FAIL div_lo: got %h want %h", lo0, 32'hFFFFFFFD); end
        n_vec++; if (hi0 !== 32'hFFFFFFFF) begin n_miss++; $display("FAIL div_hi: got %h want %h", hi0, 32'hFFFFFFFF); end
        run_op(1'b0, OP_DIVU, 32'hFFFFFFF9, 32'd2, lat);
        n_vec++; if (lo0 !== 32'h7FFFFFFC) begin n_miss++; $display("FAIL divu_lo: got %h want %h", lo0, 32'h7FFFFFFC); end
        n_vec++; if (hi0 !== 32'h00000001) begin n_miss++; $display("FAIL divu_hi: got %h want %h", hi0, 32'h1); end
    endtask

    task automatic test_div_edges();
        int lat;
        run_op(1'b0, OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat);
        n_vec++; if (lo0 !== 32'h80000000) begin n_miss++; $display("FAIL divmin_lo: got %h want %h", lo0, 32'h80000000); end
        n_vec++; if (hi0 !== 32'h0) begin n_miss++; $display("FAIL divmin_hi: got %h want %h", hi0, 32'h0); end
        n_vec++; if (dbz0 !== 1'b0) begin n_miss++; $display("FAIL divmin_dbz: got %b want 0", dbz0); end
        run_op(1'b0, OP_DIV, 32'h12345678, 32'h0, lat);
        n_vec++; if (lat != 1) begin n_miss++; $display("FAIL dbz_lat: got %0d want 1", lat); end
        n_vec++; if (dbz0 !== 1'b1) begin n_miss++; $display("FAIL dbz_flag: got %b want 1", dbz0); end
        n_vec++; if (lo0 !== 32'h80000000 || hi0 !== 32'h0) begin n_miss++; $display("FAIL dbz_hilo: got %h/%h want 00000000/80000000", hi0, lo0); end
        run_op(1'b0, OP_MTLO, 32'h00001234, 32'h0, lat);
        n_vec++; if (lat != 1) begin n_miss++; $display("FAIL mtlo_lat: got %0d want 1", lat); end
        n_vec++; if (lo0 !== 32'h00001234) begin n_miss++; $display("FAIL mtlo_lo: got %h want %h", lo0, 32'h1234); end
        n_vec++; if (dbz0 !== 1'b0) begin n_miss++; $display("FAIL mtlo_dbz: got %b want 0", dbz0); end
        run_op(1'b0, 3'd6, 32'h0000FFFF, 32'h1, lat);
        n_vec++; if (lat != 1 || lo0 !== 32'h00001234 || hi0 !== 32'h0) begin
            n_miss++; $display("FAIL reserved: got lat %0d hi %h lo %h want 1 00000000 00001234", lat, hi0, lo0);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        while (!ready0 && n < 200) begin @(posedge clk); #1; n++; end
        op_code = OP_DIVU; op_a = 32'd100; op_b = 32'd7; valid0 = 1'b1;
        @(posedge clk); #1;
        op_code = OP_MTHI; op_a = 32'h00000055; op_b = 32'h0;
        n = 1;
        while (!done0 && n < 200) begin @(posedge clk); #1; n++; end
        n_vec++; if (n != 34) begin n_miss++; $display("FAIL b2b_lat: got %0d want 34", n); end
        n_vec++; if (hi0 !== 32'd2 || lo0 !== 32'd14) begin n_miss++; $display("FAIL b2b_divu: got %h/%h want 00000002/0000000e", hi0, lo0); end
        @(posedge clk); #1;
        n_vec++; if (ready0 !== 1'b1 || done0 !== 1'b0 || hi0 !== 32'd2) begin
            n_miss++; $display("FAIL b2b_idle: got ready %b done %b hi %h want 1 0 00000002", ready0, done0, hi0);
        end
        @(posedge clk); #1;
        valid0 = 1'b0;
        n_vec++; if (done0 !== 1'b1 || hi0 !== 32'h55 || lo0 !== 32'd14) begin
            n_miss++; $display("FAIL b2b_mthi: got done %b hi %h lo %h want 1 00000055 0000000e", done0, hi0, lo0);
        end
    endtask

    task automatic test_stall();
        int n = 0;
        bit early = 1'b0;
        while (!ready0 && n < 200) begin @(posedge clk); #1; n++; end
        op_code = OP_DIVU; op_a = 32'd1000; op_b = 32'd9; valid0 = 1'b1;
        @(posedge clk); #1;
        valid0 = 1'b0; op_a = 32'hFFFFFFFF; op_b = 32'd1;
        n = 1;
        repeat (5) begin @(posedge clk); #1; n++; end
        clk_enable = 1'b0;
        repeat (5) begin @(posedge clk); #1; n++; if (done0) early = 1'b1; end
        clk_enable = 1'b1;
        while (!done0 && n < 300) begin @(posedge clk); #1; n++; end
        n_vec++; if (early) begin n_miss++; $display("FAIL stall_paused: got done during disable want none"); end
        n_vec++; if (n != 39) begin n_miss++; $display("FAIL stall_lat: got %0d want 39", n); end
        n_vec++; if (lo0 !== 32'd111 || hi0 !== 32'd1) begin n_miss++; $display("FAIL stall_result: got %h/%h want 00000001/0000006f", hi0, lo0); end
        clk_enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (done0 !== 1'b1) begin n_miss++; $display("FAIL done_hold: got %b want 1", done0); end
        clk_enable = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (done0 !== 1'b0 || ready0 !== 1'b1) begin n_miss++; $display("FAIL done_pulse: got %b/%b want 0/1", done0, ready0); end
    endtask

    task automatic test_reset_abort();
        int lat;
        int n = 0;
        int seen = 0;
        while (!ready0 && n < 200) begin @(posedge clk); #1; n++; end
        op_code = OP_DIV; op_a = 32'hFFFFFFF9; op_b = 32'd2; valid0 = 1'b1;
        @(posedge clk); #1;
        valid0 = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        n_vec++; if (hi0 !== 32'h0 || lo0 !== 32'h0) begin n_miss++; $display("FAIL abort_hilo: got %h/%h want 0/0", hi0, lo0); end
        n_vec++; if (ready0 !== 1'b1) begin n_miss++; $display("FAIL abort_ready: got %b want 1", ready0); end
        repeat (40) begin if (done0) seen++; @(posedge clk); #1; end
        n_vec++; if (seen != 0) begin n_miss++; $display("FAIL abort_done: got %0d pulses want 0", seen); end
        run_op(1'b0, OP_MULT, 32'd5, 32'd7, lat);
        n_vec++; if (lat != 2 || hi0 !== 32'h0 || lo0 !== 32'd35) begin
            n_miss++; $display("FAIL post_abort_mult: got lat %0d hi %h lo %h want 2 00000000 00000023", lat, hi0, lo0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mult();
        test_mult_iterative();
        test_div();
        test_div_edges();
        test_back_to_back();
        test_stall();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
